// File: rtl/operand_issue_stage_pkg.sv
// Shared widths, types and forwarding encodings for the ID->EX operand issue stage.
package operand_issue_stage_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int CTRL_W = 8;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [CTRL_W-1:0] ctrl_t;

   // Register 0 is the PC; it is architecturally read from the RF and never forwarded.
   localparam addr_t REG_PC = '0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   // A source matches a producer only when it names a real (non-PC) register.
   function automatic logic reg_hit(input addr_t src, input addr_t dst);
      return (src != REG_PC) && (src == dst);
   endfunction

endpackage

// File: rtl/operand_issue_stage_if.sv
// Bundle of ID-side, forwarding, control and EX-register signals around the issue stage.
interface operand_issue_stage_if;
   import operand_issue_stage_pkg::*;

   logic  id_valid;
   addr_t id_ra;
   addr_t id_rb;
   addr_t id_rc;
   logic  id_use_a;
   logic  id_use_b;
   logic  id_wr;
   logic  id_is_load;
   data_t id_pc;
   ctrl_t id_ctrl;
   data_t rf_data_a;
   data_t rf_data_b;
   data_t ex_result;
   logic  mem_wr;
   addr_t mem_rd;
   data_t mem_result;
   logic  wb_wr;
   addr_t wb_rd;
   data_t wb_result;
   logic  ex_stall;
   logic  mispredict;
   logic  freeze_ctrl;
   logic  ex_valid;
   data_t ex_op_a;
   data_t ex_op_b;
   addr_t ex_rc;
   logic  ex_wr;
   logic  ex_is_load;
   data_t ex_pc;
   ctrl_t ex_ctrl;

   modport master (
      output id_valid, id_ra, id_rb, id_rc, id_use_a, id_use_b, id_wr, id_is_load,
             id_pc, id_ctrl, rf_data_a, rf_data_b, ex_result, mem_wr, mem_rd,
             mem_result, wb_wr, wb_rd, wb_result, ex_stall, mispredict,
      input  freeze_ctrl, ex_valid, ex_op_a, ex_op_b, ex_rc, ex_wr, ex_is_load,
             ex_pc, ex_ctrl
   );

   modport slave (
      input  id_valid, id_ra, id_rb, id_rc, id_use_a, id_use_b, id_wr, id_is_load,
             id_pc, id_ctrl, rf_data_a, rf_data_b, ex_result, mem_wr, mem_rd,
             mem_result, wb_wr, wb_rd, wb_result, ex_stall, mispredict,
      output freeze_ctrl, ex_valid, ex_op_a, ex_op_b, ex_rc, ex_wr, ex_is_load,
             ex_pc, ex_ctrl
   );

endinterface

// File: rtl/operand_issue_stage_fwd_mux.sv
// Per-source operand forwarding mux. Also reports whether the source depends on
// the EX-stage destination so the top can detect load-use hazards.
module operand_issue_stage_fwd_mux
   import operand_issue_stage_pkg::*;
(
   input  addr_t src,
   input  logic  use_src,
   input  data_t rf_data,
   input  logic  ex_fwd_en,
   input  addr_t ex_rc,
   input  data_t ex_result,
   input  logic  mem_wr,
   input  addr_t mem_rd,
   input  data_t mem_result,
   input  logic  wb_wr,
   input  addr_t wb_rd,
   input  data_t wb_result,
   output data_t operand,
   output logic  ex_dep
);

   fwd_sel_e sel;

   // Youngest matching producer wins; the PC register always comes from the RF.
   always_comb begin
      sel = FWD_RF;
      if (src == REG_PC) begin
         sel = FWD_RF;
      end else if (ex_fwd_en && reg_hit(src, ex_rc)) begin
         sel = FWD_EX;
      end else if (mem_wr && reg_hit(src, mem_rd)) begin
         sel = FWD_MEM;
      end else if (wb_wr && reg_hit(src, wb_rd)) begin
         sel = FWD_WB;
      end
   end

   // Operand data steering from the chosen source.
   always_comb begin
      operand = rf_data;
      case (sel)
         FWD_EX:  operand = ex_result;
         FWD_MEM: operand = mem_result;
         FWD_WB:  operand = wb_result;
         default: operand = rf_data;
      endcase
   end

   assign ex_dep = use_src && reg_hit(src, ex_rc);

endmodule

// File: rtl/operand_issue_stage.sv
// ID->EX issue stage: operand forwarding, load-use bubble insertion with upstream
// freeze, branch-mispredict kill, and the EX pipeline register.
module operand_issue_stage
   import operand_issue_stage_pkg::*;
(
   input logic                   clk,
   input logic                   rst_n,
   operand_issue_stage_if.slave  bus
);

   logic  ex_valid_q,   ex_valid_d;
   logic  ex_wr_q,      ex_wr_d;
   logic  ex_is_load_q, ex_is_load_d;
   data_t ex_op_a_q,    ex_op_a_d;
   data_t ex_op_b_q,    ex_op_b_d;
   addr_t ex_rc_q,      ex_rc_d;
   data_t ex_pc_q,      ex_pc_d;
   ctrl_t ex_ctrl_q,    ex_ctrl_d;

   data_t fwd_a;
   data_t fwd_b;
   logic  dep_a;
   logic  dep_b;
   logic  ex_fwd_en;
   logic  load_use;

   // A load in EX has no data yet, so it is excluded from EX forwarding.
   assign ex_fwd_en = ex_valid_q && ex_wr_q && !ex_is_load_q;

   operand_issue_stage_fwd_mux u_fwd_a (
      .src        (bus.id_ra),
      .use_src    (bus.id_use_a),
      .rf_data    (bus.rf_data_a),
      .ex_fwd_en  (ex_fwd_en),
      .ex_rc      (ex_rc_q),
      .ex_result  (bus.ex_result),
      .mem_wr     (bus.mem_wr),
      .mem_rd     (bus.mem_rd),
      .mem_result (bus.mem_result),
      .wb_wr      (bus.wb_wr),
      .wb_rd      (bus.wb_rd),
      .wb_result  (bus.wb_result),
      .operand    (fwd_a),
      .ex_dep     (dep_a)
   );

   operand_issue_stage_fwd_mux u_fwd_b (
      .src        (bus.id_rb),
      .use_src    (bus.id_use_b),
      .rf_data    (bus.rf_data_b),
      .ex_fwd_en  (ex_fwd_en),
      .ex_rc      (ex_rc_q),
      .ex_result  (bus.ex_result),
      .mem_wr     (bus.mem_wr),
      .mem_rd     (bus.mem_rd),
      .mem_result (bus.mem_result),
      .wb_wr      (bus.wb_wr),
      .wb_rd      (bus.wb_rd),
      .wb_result  (bus.wb_result),
      .operand    (fwd_b),
      .ex_dep     (dep_b)
   );

   // Load-use hazard and upstream freeze; a mispredict overrides both, and reset forces freeze low.
   always_comb begin
      load_use = bus.id_valid && ex_valid_q && ex_is_load_q && ex_wr_q && (dep_a || dep_b);
      bus.freeze_ctrl = rst_n && !bus.mispredict && (load_use || bus.ex_stall);
   end

   // EX register next-state: flush > stall hold > bubble > capture.
   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_wr_d      = ex_wr_q;
      ex_is_load_d = ex_is_load_q;
      ex_op_a_d    = ex_op_a_q;
      ex_op_b_d    = ex_op_b_q;
      ex_rc_d      = ex_rc_q;
      ex_pc_d      = ex_pc_q;
      ex_ctrl_d    = ex_ctrl_q;
      if (bus.mispredict) begin
         ex_valid_d   = 1'b0;
         ex_wr_d      = 1'b0;
         ex_is_load_d = 1'b0;
      end else if (bus.ex_stall) begin
         // hold everything
      end else if (load_use) begin
         ex_valid_d   = 1'b0;
         ex_wr_d      = 1'b0;
         ex_is_load_d = 1'b0;
      end else begin
         ex_valid_d   = bus.id_valid;
         ex_wr_d      = bus.id_valid && bus.id_wr;
         ex_is_load_d = bus.id_valid && bus.id_is_load;
         ex_op_a_d    = fwd_a;
         ex_op_b_d    = fwd_b;
         ex_rc_d      = bus.id_rc;
         ex_pc_d      = bus.id_pc;
         ex_ctrl_d    = bus.id_ctrl;
      end
   end

   // EX pipeline register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q   <= 1'b0;
         ex_wr_q      <= 1'b0;
         ex_is_load_q <= 1'b0;
         ex_op_a_q    <= '0;
         ex_op_b_q    <= '0;
         ex_rc_q      <= '0;
         ex_pc_q      <= '0;
         ex_ctrl_q    <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_wr_q      <= ex_wr_d;
         ex_is_load_q <= ex_is_load_d;
         ex_op_a_q    <= ex_op_a_d;
         ex_op_b_q    <= ex_op_b_d;
         ex_rc_q      <= ex_rc_d;
         ex_pc_q      <= ex_pc_d;
         ex_ctrl_q    <= ex_ctrl_d;
      end
   end

   assign bus.ex_valid   = ex_valid_q;
   assign bus.ex_wr      = ex_wr_q;
   assign bus.ex_is_load = ex_is_load_q;
   assign bus.ex_op_a    = ex_op_a_q;
   assign bus.ex_op_b    = ex_op_b_q;
   assign bus.ex_rc      = ex_rc_q;
   assign bus.ex_pc      = ex_pc_q;
   assign bus.ex_ctrl    = ex_ctrl_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed and randomized checks of the operand issue stage against a behavioural model.
module tb_operand_issue_stage;
   import operand_issue_stage_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   operand_issue_stage_if bus ();

   operand_issue_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic  valid;
      logic  wr;
      logic  load;
      addr_t rc;
      data_t op_a;
      data_t op_b;
      data_t pc;
      ctrl_t ctrl;
   } ex_model_t;

   ex_model_t mdl;

   task automatic drive_idle();
      bus.id_valid = 0; bus.id_ra = 0; bus.id_rb = 0; bus.id_rc = 0;
      bus.id_use_a = 0; bus.id_use_b = 0; bus.id_wr = 0; bus.id_is_load = 0;
      bus.id_pc = 0; bus.id_ctrl = 0; bus.rf_data_a = 0; bus.rf_data_b = 0;
      bus.ex_result = 0; bus.mem_wr = 0; bus.mem_rd = 0; bus.mem_result = 0;
      bus.wb_wr = 0; bus.wb_rd = 0; bus.wb_result = 0; bus.ex_stall = 0;
      bus.mispredict = 0;
   endtask

   task automatic set_id(input logic ld, input addr_t ra, input addr_t rb, input addr_t rc,
                         input logic ua, input logic ub, input logic wr, input data_t pc);
      bus.id_valid = 1; bus.id_ra = ra; bus.id_rb = rb; bus.id_rc = rc;
      bus.id_use_a = ua; bus.id_use_b = ub; bus.id_wr = wr; bus.id_is_load = ld;
      bus.id_pc = pc; bus.id_ctrl = pc[7:0] ^ 8'h5A;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      set_id(0, 1, 2, 3, 1, 1, 1, 16'h0077);
      cycle();
      cycle();
      #2;
      rst_n = 0;
      bus.ex_stall = 1;
      #1;
      checks++;
      if ({bus.ex_valid, bus.ex_wr, bus.ex_is_load} !== 3'b000 || bus.ex_pc !== 16'h0 ||
          bus.ex_op_a !== 16'h0 || bus.ex_rc !== 3'h0 || bus.ex_ctrl !== 8'h0) begin
         errors++;
         $display("FAIL reset_clear: valid=%b pc=%h op_a=%h rc=%h ctrl=%h, want all 0",
                  bus.ex_valid, bus.ex_pc, bus.ex_op_a, bus.ex_rc, bus.ex_ctrl);
      end
      checks++;
      if (bus.freeze_ctrl !== 1'b0) begin
         errors++;
         $display("FAIL reset_freeze: freeze_ctrl=%b want 0", bus.freeze_ctrl);
      end
      cycle();
      rst_n = 1;
      bus.ex_stall = 0;
      set_id(0, 1, 2, 3, 1, 1, 1, 16'h0055);
      #1;
      checks++;
      if (bus.ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_empty: ex_valid=%b want 0", bus.ex_valid);
      end
      cycle();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 16'h0055) begin
         errors++;
         $display("FAIL post_reset_capture: valid=%b pc=%h want 1/0055", bus.ex_valid, bus.ex_pc);
      end
   endtask

   task automatic test_ex_forward();
      drive_idle();
      set_id(0, 1, 1, 3, 0, 0, 1, 16'h0100);
      cycle();
      set_id(0, 3, 1, 5, 1, 0, 1, 16'h0101);
      bus.rf_data_a = 16'h0000;
      bus.ex_result = 16'h0010;
      cycle();
      checks++;
      if (bus.ex_op_a !== 16'h0010 || bus.ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL ex_forward: op_a=%h valid=%b want 0010/1", bus.ex_op_a, bus.ex_valid);
      end
   endtask

   task automatic test_mem_over_wb();
      drive_idle();
      set_id(0, 1, 2, 1, 0, 1, 1, 16'h0200);
      bus.rf_data_b = 16'h0CCC;
      bus.mem_wr = 1; bus.mem_rd = 2; bus.mem_result = 16'h00AA;
      bus.wb_wr = 1; bus.wb_rd = 2; bus.wb_result = 16'h00BB;
      cycle();
      checks++;
      if (bus.ex_op_b !== 16'h00AA) begin
         errors++;
         $display("FAIL mem_over_wb: op_b=%h want 00aa", bus.ex_op_b);
      end
      drive_idle();
      set_id(0, 6, 1, 1, 1, 0, 0, 16'h0201);
      bus.rf_data_a = 16'h0C0C;
      bus.wb_wr = 1; bus.wb_rd = 6; bus.wb_result = 16'h00BB;
      cycle();
      checks++;
      if (bus.ex_op_a !== 16'h00BB) begin
         errors++;
         $display("FAIL wb_forward: op_a=%h want 00bb", bus.ex_op_a);
      end
   endtask

   task automatic test_load_use();
      drive_idle();
      set_id(1, 1, 1, 4, 0, 0, 1, 16'h0300);
      cycle();
      set_id(0, 4, 1, 5, 1, 0, 1, 16'h0301);
      #1;
      checks++;
      if (bus.freeze_ctrl !== 1'b1) begin
         errors++;
         $display("FAIL load_use_freeze: freeze_ctrl=%b want 1", bus.freeze_ctrl);
      end
      cycle();
      checks++;
      if (bus.ex_valid !== 1'b0 || bus.ex_wr !== 1'b0) begin
         errors++;
         $display("FAIL load_use_bubble: valid=%b wr=%b want 0/0", bus.ex_valid, bus.ex_wr);
      end
      bus.mem_wr = 1; bus.mem_rd = 4; bus.mem_result = 16'h1234;
      #1;
      checks++;
      if (bus.freeze_ctrl !== 1'b0) begin
         errors++;
         $display("FAIL load_use_release: freeze_ctrl=%b want 0", bus.freeze_ctrl);
      end
      cycle();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_op_a !== 16'h1234 || bus.ex_pc !== 16'h0301) begin
         errors++;
         $display("FAIL load_use_reissue: valid=%b op_a=%h pc=%h want 1/1234/0301",
                  bus.ex_valid, bus.ex_op_a, bus.ex_pc);
      end
   endtask

   task automatic test_flush_load_use();
      drive_idle();
      set_id(1, 1, 1, 4, 0, 0, 1, 16'h0400);
      cycle();
      set_id(0, 1, 4, 5, 0, 1, 1, 16'h0401);
      bus.mispredict = 1;
      #1;
      checks++;
      if (bus.freeze_ctrl !== 1'b0) begin
         errors++;
         $display("FAIL flush_load_use_freeze: freeze_ctrl=%b want 0", bus.freeze_ctrl);
      end
      cycle();
      checks++;
      if ({bus.ex_valid, bus.ex_wr, bus.ex_is_load} !== 3'b000) begin
         errors++;
         $display("FAIL flush_load_use_kill: flags=%b want 000",
                  {bus.ex_valid, bus.ex_wr, bus.ex_is_load});
      end
   endtask

   task automatic test_stall_flush();
      drive_idle();
      set_id(0, 1, 1, 2, 0, 0, 1, 16'h0500);
      cycle();
      set_id(0, 1, 1, 3, 0, 0, 1, 16'h0501);
      bus.ex_stall = 1;
      #1;
      checks++;
      if (bus.freeze_ctrl !== 1'b1) begin
         errors++;
         $display("FAIL stall_freeze: freeze_ctrl=%b want 1", bus.freeze_ctrl);
      end
      cycle();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 16'h0500 || bus.ex_rc !== 3'd2) begin
         errors++;
         $display("FAIL stall_hold: valid=%b pc=%h rc=%0d want 1/0500/2",
                  bus.ex_valid, bus.ex_pc, bus.ex_rc);
      end
      bus.mispredict = 1;
      #1;
      checks++;
      if (bus.freeze_ctrl !== 1'b0) begin
         errors++;
         $display("FAIL stall_flush_freeze: freeze_ctrl=%b want 0", bus.freeze_ctrl);
      end
      cycle();
      checks++;
      if (bus.ex_valid !== 1'b0 || bus.ex_wr !== 1'b0) begin
         errors++;
         $display("FAIL stall_flush_kill: valid=%b wr=%b want 0/0", bus.ex_valid, bus.ex_wr);
      end
   endtask

   task automatic test_r0_no_forward();
      drive_idle();
      set_id(0, 1, 1, 0, 0, 0, 1, 16'h0600);
      cycle();
      set_id(0, 0, 1, 1, 1, 0, 1, 16'h0601);
      bus.rf_data_a = 16'h7777;
      bus.ex_result = 16'h9999;
      bus.mem_wr = 1; bus.mem_rd = 0; bus.mem_result = 16'h8888;
      bus.wb_wr = 1; bus.wb_rd = 0; bus.wb_result = 16'h6666;
      cycle();
      checks++;
      if (bus.ex_op_a !== 16'h7777) begin
         errors++;
         $display("FAIL r0_no_forward: op_a=%h want 7777", bus.ex_op_a);
      end
   endtask

   // Reference: the freshest in-flight producer of a register supplies its value;
   // register 0 and loads still in EX are never sources.
   function automatic data_t ref_operand(input addr_t s, input data_t d);
      logic  en  [3];
      addr_t rd  [3];
      data_t val [3];
      en[0] = mdl.valid && mdl.wr && !mdl.load; rd[0] = mdl.rc;     val[0] = bus.ex_result;
      en[1] = bus.mem_wr;                       rd[1] = bus.mem_rd; val[1] = bus.mem_result;
      en[2] = bus.wb_wr;                        rd[2] = bus.wb_rd;  val[2] = bus.wb_result;
      if (s == 0) return d;
      for (int k = 0; k < 3; k++) begin
         if (en[k] && rd[k] == s) return val[k];
      end
      return d;
   endfunction

   task automatic test_random();
      logic      lu;
      logic      exp_freeze;
      ex_model_t nxt;
      drive_idle();
      rst_n = 0;
      #2;
      rst_n = 1;
      mdl = '{default: '0};
      for (int n = 0; n < 400; n++) begin
         bus.id_valid   = ($urandom_range(0, 7) != 0);
         bus.id_ra      = addr_t'($urandom_range(0, 4));
         bus.id_rb      = addr_t'($urandom_range(0, 4));
         bus.id_rc      = addr_t'($urandom_range(0, 4));
         bus.id_use_a   = $urandom_range(0, 1);
         bus.id_use_b   = $urandom_range(0, 1);
         bus.id_wr      = ($urandom_range(0, 3) != 0);
         bus.id_is_load = ($urandom_range(0, 2) == 0);
         bus.id_pc      = data_t'($urandom);
         bus.id_ctrl    = ctrl_t'($urandom);
         bus.rf_data_a  = data_t'($urandom);
         bus.rf_data_b  = data_t'($urandom);
         bus.ex_result  = data_t'($urandom);
         bus.mem_wr     = $urandom_range(0, 1);
         bus.mem_rd     = addr_t'($urandom_range(0, 4));
         bus.mem_result = data_t'($urandom);
         bus.wb_wr      = $urandom_range(0, 1);
         bus.wb_rd      = addr_t'($urandom_range(0, 4));
         bus.wb_result  = data_t'($urandom);
         bus.ex_stall   = ($urandom_range(0, 5) == 0);
         bus.mispredict = ($urandom_range(0, 7) == 0);
         lu = bus.id_valid && mdl.valid && mdl.load && mdl.wr &&
              ((bus.id_use_a && bus.id_ra != 0 && bus.id_ra == mdl.rc) ||
               (bus.id_use_b && bus.id_rb != 0 && bus.id_rb == mdl.rc));
         exp_freeze = !bus.mispredict && (lu || bus.ex_stall);
         nxt = mdl;
         if (bus.mispredict || (!bus.ex_stall && lu)) begin
            nxt.valid = 0; nxt.wr = 0; nxt.load = 0;
         end else if (!bus.ex_stall) begin
            nxt.valid = bus.id_valid;
            nxt.wr    = bus.id_valid && bus.id_wr;
            nxt.load  = bus.id_valid && bus.id_is_load;
            nxt.rc    = bus.id_rc;
            nxt.op_a  = ref_operand(bus.id_ra, bus.rf_data_a);
            nxt.op_b  = ref_operand(bus.id_rb, bus.rf_data_b);
            nxt.pc    = bus.id_pc;
            nxt.ctrl  = bus.id_ctrl;
         end
         #1;
         checks++;
         if (bus.freeze_ctrl !== exp_freeze) begin
            errors++;
            $display("FAIL rand_freeze[%0d]: freeze_ctrl=%b want %b", n, bus.freeze_ctrl, exp_freeze);
         end
         cycle();
         mdl = nxt;
         checks++;
         if ({bus.ex_valid, bus.ex_wr, bus.ex_is_load} !== {mdl.valid, mdl.wr, mdl.load}) begin
            errors++;
            $display("FAIL rand_flags[%0d]: flags=%b want %b", n,
                     {bus.ex_valid, bus.ex_wr, bus.ex_is_load}, {mdl.valid, mdl.wr, mdl.load});
         end
         if (mdl.valid) begin
            checks++;
            if (bus.ex_op_a !== mdl.op_a || bus.ex_op_b !== mdl.op_b || bus.ex_rc !== mdl.rc ||
                bus.ex_pc !== mdl.pc || bus.ex_ctrl !== mdl.ctrl) begin
               errors++;
               $display("FAIL rand_data[%0d]: a=%h b=%h rc=%0d pc=%h ctrl=%h want a=%h b=%h rc=%0d pc=%h ctrl=%h",
                        n, bus.ex_op_a, bus.ex_op_b, bus.ex_rc, bus.ex_pc, bus.ex_ctrl,
                        mdl.op_a, mdl.op_b, mdl.rc, mdl.pc, mdl.ctrl);
            end
         end
      end
   endtask

   initial begin
      drive_idle();
      rst_n = 0;
      #12;
      rst_n = 1;
      cycle();
      test_reset();
      test_ex_forward();
      test_mem_over_wb();
      test_load_use();
      test_flush_load_use();
      test_stall_flush();
      test_r0_no_forward();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
